bclk_training_ctrl: RTL and testbench
=====================================

Name: bclk_training_ctrl

Overview:
- Fabric-side training controller for one BCLK_TRAINING receive IOD lane in the DDR4 PHY block.
- Drives the lane's dynamic delay-line controls (LOAD, MOVE, DIRECTION) and eye-monitor flag clear.
- Consumes the deserialised RX_DATA, EYE_MONITOR_EARLY/LATE and DELAY_LINE_OUT_OF_RANGE.
- Sweeps the delay line to find two BCLK transitions, then parks the tap midway between them and reports the result.

Parameters:
TAP_MAX, 127, highest legal delay tap; the sweep stops here.
SETTLE_CYC, 8, FAB_CLK cycles waited after a load or move before sampling.
SAMPLE_CNT, 16, RX_DATA words examined per tap (≥2).

Ports:
FAB_CLK  in  1  fabric clock, same clock as the IOD RX_CLK.
ARST_N  in  1  reset: asynchronous, active-low.
TRAIN_START  in  1  one-cycle start/restart request.
RX_DATA  in  8  deserialised BCLK samples from the IOD.
EYE_MONITOR_EARLY  in  1  IOD early flag.
EYE_MONITOR_LATE  in  1  IOD late flag.
DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line range error.
DELAY_LINE_LOAD  out  1  one-cycle pulse; returns the delay line to tap 0.
DELAY_LINE_MOVE  out  1  one-cycle pulse; moves the delay line one tap.
DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid while MOVE is high.
EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse; clears the eye flags.
TRAIN_BUSY  out  1  high in every state except IDLE, DONE and ERR.
TRAIN_DONE  out  1  level; training succeeded.
TRAIN_ERR  out  1  level; training failed.
ERR_CODE  out  2  failure cause: 01 = no edge found, 10 = only one edge found, 11 = out of range.
TAP_COUNT  out  8  controller's copy of the current tap.
EDGE_A  out  8  tap of the first transition.
EDGE_B  out  8  tap of the second transition.
CENTER_TAP  out  8  final tap, (EDGE_A+EDGE_B)>>1.

Behaviour:
- Reset (async assert, sync release): all outputs are 0; state is IDLE.
- Every output is registered; outputs change only in the cycle after the state change.
- States: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, CHKRNG, CENTER, DONE, ERR.
- IDLE/DONE/ERR + TRAIN_START → LOAD. This clears DONE, ERR, ERR_CODE, EDGE_A/B and the phase flags.
- TRAIN_START is ignored in all other states.
- LOAD: DELAY_LINE_LOAD=1 for 1 cycle; TAP_COUNT←0 → CLEAR.
- CLEAR: EYE_MONITOR_CLEAR_FLAGS=1 for 1 cycle; settle counter←0 → SETTLE.
- SETTLE: wait exactly SETTLE_CYC cycles → SAMPLE.
- SAMPLE: lasts SAMPLE_CNT cycles.
  - Cycle 0 captures REF=RX_DATA.
  - In each later cycle, UNSTABLE is set if RX_DATA≠REF.
  - In any sample cycle, UNSTABLE is set if EYE_MONITOR_EARLY|LATE=1.
  - Then → EVAL.
- EVAL phases (evaluated in this order):
  - phase0: UNSTABLE → EDGE_A←TAP_COUNT, phase←1.
  - phase1: !UNSTABLE → phase←2 (stable gap seen).
  - phase2: UNSTABLE → EDGE_B←TAP_COUNT, CENTER_TAP←(EDGE_A+EDGE_B)>>1 using a 9-bit sum, → CENTER.
  - Otherwise, if TAP_COUNT<TAP_MAX → STEP.
  - Otherwise, at TAP_COUNT==TAP_MAX → ERR with ERR_CODE=01 (phase0) or 10 (phase1/2).
- STEP: MOVE=1, DIRECTION=1 for 1 cycle; TAP_COUNT+1 → CHKRNG.
- CHKRNG (1 cycle): DELAY_LINE_OUT_OF_RANGE=1 → ERR with code 11, else → CLEAR.
- CENTER:
  - Issues MOVE=1, DIRECTION=0 pulses separated by ≥1 idle cycle.
  - TAP_COUNT decrements on each pulse.
  - OUT_OF_RANGE=1 on the cycle after a pulse → ERR with code 11.
  - TAP_COUNT==CENTER_TAP → DONE (EDGE_B==EDGE_A cannot occur).
- DIRECTION is 0 whenever MOVE is 0. MOVE and LOAD are never high together.
- DONE/ERR: levels are held until the next TRAIN_START or reset.
- TAP_COUNT never wraps: the STEP guard keeps it ≤ TAP_MAX.
- Reset mid-training: all outputs clear immediately; the delay line is reloaded only by the next LOAD.

Test Plan:
- Model: delay-line taps 0..127; RX_DATA=8'hF0 everywhere except unstable taps 20–22 and 60–62, where it alternates F0/E0. Stimulus: TRAIN_START → EDGE_A=20, EDGE_B=60, CENTER_TAP=40, TAP_COUNT=40, TRAIN_DONE=1, exactly 60 up-pulses, 20 down-pulses and 1 LOAD pulse.
- Model with all taps stable → TRAIN_ERR=1, ERR_CODE=01, TAP_COUNT=127, DONE=0.
- Model with unstable taps only at 30–35 → ERR_CODE=10, EDGE_A=30.
- Stable data but EYE_MONITOR_LATE pulsed during SAMPLE at tap 10, unstable data at tap 50 → EDGE_A=10, EDGE_B=50, CENTER_TAP=30.
- OUT_OF_RANGE forced high after the 5th up-pulse → ERR_CODE=11, TAP_COUNT=5, no further MOVE pulses.
- ARST_N low during CENTER → all outputs 0 within the same cycle. Then TRAIN_START → training restarts with a LOAD pulse and completes as in the first scenario.
- Protocol checks on every run: SETTLE_CYC idle cycles between each CLEAR and the first sample; TRAIN_START ignored while TRAIN_BUSY=1.

Source files
------------

// File: rtl/bclk_training_ctrl.sv
// Training controller for one BCLK receive IOD lane: sweeps the delay line to find two
// BCLK transitions, then parks the tap midway between them and reports the result.
module bclk_training_ctrl #(
  parameter int unsigned TAP_MAX    = 127,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned SAMPLE_CNT = 16
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRAIN_START,
  input  logic [7:0] RX_DATA,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERR,
  output logic [1:0] ERR_CODE,
  output logic [7:0] TAP_COUNT,
  output logic [7:0] EDGE_A,
  output logic [7:0] EDGE_B,
  output logic [7:0] CENTER_TAP
);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StClear,
    StSettle,
    StSample,
    StEval,
    StStep,
    StChkRng,
    StCenter,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] ErrNoEdge  = 2'b01;
  localparam logic [1:0] ErrOneEdge = 2'b10;
  localparam logic [1:0] ErrRange   = 2'b11;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ref_q, ref_d;
  logic       unstable_q, unstable_d;
  logic [1:0] phase_q, phase_d;
  logic       gap_q, gap_d;
  logic [7:0] tap_q, tap_d;
  logic [7:0] edge_a_q, edge_a_d;
  logic [7:0] edge_b_q, edge_b_d;
  logic [7:0] center_q, center_d;
  logic       load_q, load_d;
  logic       move_q, move_d;
  logic       dir_q, dir_d;
  logic       clr_q, clr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;

  logic [8:0] mid_sum;
  logic       second_edge;

  // Nine-bit sum so the midpoint never loses the carry.
  assign mid_sum = {1'b0, edge_a_q} + {1'b0, tap_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ref_d       = ref_q;
    unstable_d  = unstable_q;
    phase_d     = phase_q;
    gap_d       = gap_q;
    tap_d       = tap_q;
    edge_a_d    = edge_a_q;
    edge_b_d    = edge_b_q;
    center_d    = center_q;
    done_d      = done_q;
    err_d       = err_q;
    code_d      = code_q;
    load_d      = 1'b0;
    move_d      = 1'b0;
    dir_d       = 1'b0;
    clr_d       = 1'b0;
    second_edge = 1'b0;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (TRAIN_START) begin
          state_d  = StLoad;
          done_d   = 1'b0;
          err_d    = 1'b0;
          code_d   = 2'b00;
          edge_a_d = 8'd0;
          edge_b_d = 8'd0;
          phase_d  = 2'd0;
        end
      end
      StLoad: begin
        load_d  = 1'b1;
        tap_d   = 8'd0;
        state_d = StClear;
      end
      StClear: begin
        clr_d   = 1'b1;
        cnt_d   = 8'd0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == 8'(SETTLE_CYC - 1)) begin
          cnt_d      = 8'd0;
          unstable_d = 1'b0;
          state_d    = StSample;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSample: begin
        if (cnt_q == 8'd0) begin
          ref_d = RX_DATA;
        end else if (RX_DATA != ref_q) begin
          unstable_d = 1'b1;
        end
        if (EYE_MONITOR_EARLY || EYE_MONITOR_LATE) begin
          unstable_d = 1'b1;
        end
        if (cnt_q == 8'(SAMPLE_CNT - 1)) begin
          state_d = StEval;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StEval: begin
        if (phase_q == 2'd0 && unstable_q) begin
          edge_a_d = tap_q;
          phase_d  = 2'd1;
        end else if (phase_q == 2'd1 && !unstable_q) begin
          phase_d = 2'd2;
        end else if (phase_q == 2'd2 && unstable_q) begin
          second_edge = 1'b1;
          edge_b_d    = tap_q;
          center_d    = mid_sum[8:1];
          gap_d       = 1'b0;
          state_d     = StCenter;
        end
        if (!second_edge) begin
          if (tap_q < 8'(TAP_MAX)) begin
            state_d = StStep;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
            code_d  = (phase_d == 2'd0) ? ErrNoEdge : ErrOneEdge;
          end
        end
      end
      StStep: begin
        move_d  = 1'b1;
        dir_d   = 1'b1;
        tap_d   = tap_q + 8'd1;
        state_d = StChkRng;
      end
      StChkRng: begin
        // Runs while the registered MOVE pulse is on the lane.
        if (DELAY_LINE_OUT_OF_RANGE) begin
          state_d = StErr;
          err_d   = 1'b1;
          code_d  = ErrRange;
        end else begin
          state_d = StClear;
        end
      end
      StCenter: begin
        // gap_q marks the cycle the down pulse is visible; range is checked then.
        if (gap_q) begin
          gap_d = 1'b0;
          if (DELAY_LINE_OUT_OF_RANGE) begin
            state_d = StErr;
            err_d   = 1'b1;
            code_d  = ErrRange;
          end
        end else if (tap_q == center_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          move_d = 1'b1;
          tap_d  = tap_q - 8'd1;
          gap_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = !(state_d inside {StIdle, StDone, StErr});
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      ref_q      <= 8'd0;
      unstable_q <= 1'b0;
      phase_q    <= 2'd0;
      gap_q      <= 1'b0;
      tap_q      <= 8'd0;
      edge_a_q   <= 8'd0;
      edge_b_q   <= 8'd0;
      center_q   <= 8'd0;
      load_q     <= 1'b0;
      move_q     <= 1'b0;
      dir_q      <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_q      <= ref_d;
      unstable_q <= unstable_d;
      phase_q    <= phase_d;
      gap_q      <= gap_d;
      tap_q      <= tap_d;
      edge_a_q   <= edge_a_d;
      edge_b_q   <= edge_b_d;
      center_q   <= center_d;
      load_q     <= load_d;
      move_q     <= move_d;
      dir_q      <= dir_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
  assign TRAIN_BUSY              = busy_q;
  assign TRAIN_DONE              = done_q;
  assign TRAIN_ERR               = err_q;
  assign ERR_CODE                = code_q;
  assign TAP_COUNT               = tap_q;
  assign EDGE_A                  = edge_a_q;
  assign EDGE_B                  = edge_b_q;
  assign CENTER_TAP              = center_q;

endmodule

// File: tb/tb_bclk_training_ctrl.sv
// Scoreboard bench for bclk_training_ctrl: a behavioural delay-line/lane model feeds the DUT,
// a reference sweep predicts each training result, and a monitor checks it on completion.
module tb_bclk_training_ctrl;

  localparam int SETTLE  = 8;
  localparam int SAMPLES = 16;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N = 1'b0;
  logic       TRAIN_START = 1'b0;
  logic [7:0] RX_DATA = 8'hF0;
  logic       EYE_MONITOR_EARLY = 1'b0;
  logic       EYE_MONITOR_LATE = 1'b0;
  logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
  logic       TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR;
  logic [1:0] ERR_CODE;
  logic [7:0] TAP_COUNT, EDGE_A, EDGE_B, CENTER_TAP;

  bclk_training_ctrl #(
    .TAP_MAX   (127),
    .SETTLE_CYC(SETTLE),
    .SAMPLE_CNT(SAMPLES)
  ) dut (
    .FAB_CLK                (FAB_CLK),
    .ARST_N                 (ARST_N),
    .TRAIN_START            (TRAIN_START),
    .RX_DATA                (RX_DATA),
    .EYE_MONITOR_EARLY      (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE       (EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_LOAD        (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE        (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION   (DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .TRAIN_BUSY             (TRAIN_BUSY),
    .TRAIN_DONE             (TRAIN_DONE),
    .TRAIN_ERR              (TRAIN_ERR),
    .ERR_CODE               (ERR_CODE),
    .TAP_COUNT              (TAP_COUNT),
    .EDGE_A                 (EDGE_A),
    .EDGE_B                 (EDGE_B),
    .CENTER_TAP             (CENTER_TAP)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    int done;
    int err;
    int code;
    int tap;
    int ea;
    int eb;
    int ct;
    int ups;
    int downs;
    int loads;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Lane model configuration
  bit       unst[128];
  int       late_tap = -1;
  int       oor_after = 0;
  logic [7:0] base_val = 8'hF0;
  logic [7:0] alt_val = 8'hE0;

  // Lane model state
  int n_load = 0, n_up = 0, n_down = 0;
  int mtap = 0;
  int clr_age = 0;
  bit tog = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 128; i++) unst[i] = 1'b0;
    late_tap  = -1;
    oor_after = 0;
    base_val  = 8'hF0;
    alt_val   = 8'hE0;
  endtask

  // Sweep the taps as the training rules describe and predict the final report.
  function automatic exp_t ref_model();
    exp_t e;
    int   ph, a;
    bit   u;
    e = '{default: 0};
    ph = 0;
    a = 0;
    for (int t = 0; t < 128; t++) begin
      u = unst[t] || (t == late_tap);
      e.tap = t;
      if (ph == 0 && u) begin
        a = t;
        ph = 1;
      end else if (ph == 1 && !u) begin
        ph = 2;
      end else if (ph == 2 && u) begin
        e.done = 1; e.ea = a; e.eb = t; e.ct = (a + t) / 2;
        e.tap = e.ct; e.ups = t; e.downs = t - e.ct;
        break;
      end
      if (t == 127) begin
        e.err = 1; e.code = (ph == 0) ? 1 : 2; e.ea = (ph == 0) ? 0 : a; e.ups = 127;
        break;
      end
      if (oor_after != 0 && t + 1 == oor_after) begin
        e.err = 1; e.code = 3; e.tap = t + 1; e.ea = (ph == 0) ? 0 : a; e.ups = t + 1;
        break;
      end
    end
    e.loads = 1;
    return e;
  endfunction

  // Delay line / IOD model plus per-cycle protocol checks.
  initial begin
    forever begin
      @(negedge FAB_CLK);
      if (TRAIN_START && !TRAIN_BUSY && ARST_N) begin
        n_load = 0; n_up = 0; n_down = 0; clr_age = 0;
      end
      if (ARST_N) begin
        chk("dir_without_move", int'(DELAY_LINE_DIRECTION && !DELAY_LINE_MOVE), 0);
        chk("move_with_load", int'(DELAY_LINE_MOVE && DELAY_LINE_LOAD), 0);
      end
      if (DELAY_LINE_LOAD) begin
        n_load++;
        mtap = 0;
      end
      if (DELAY_LINE_MOVE) begin
        if (DELAY_LINE_DIRECTION) begin
          total++;
          if (clr_age < SETTLE + SAMPLES) begin
            bad++;
            $display("FAIL settle_gap: move %0d cycles after clear, need >= %0d",
                     clr_age, SETTLE + SAMPLES);
          end
          n_up++;
          mtap++;
        end else begin
          n_down++;
          mtap--;
        end
      end
      if (EYE_MONITOR_CLEAR_FLAGS) clr_age = 0;
      else clr_age++;
      tog = ~tog;
      RX_DATA = (mtap >= 0 && mtap < 128 && unst[mtap] && tog) ? alt_val : base_val;
      EYE_MONITOR_LATE = (mtap == late_tap) && (clr_age == SETTLE + 4);
      DELAY_LINE_OUT_OF_RANGE = (oor_after != 0) && (n_up >= oor_after);
    end
  end

  // Monitor: pops an expectation whenever a run finishes.
  initial begin
    bit   prev_fin;
    bit   fin;
    exp_t e;
    prev_fin = 1'b0;
    forever begin
      @(negedge FAB_CLK);
      fin = TRAIN_DONE || TRAIN_ERR;
      if (fin && !prev_fin) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_finish: done=%0d err=%0d with no run pending",
                   TRAIN_DONE, TRAIN_ERR);
        end else begin
          e = sb.pop_front();
          chk("train_done", int'(TRAIN_DONE), e.done);
          chk("train_err", int'(TRAIN_ERR), e.err);
          chk("err_code", int'(ERR_CODE), e.code);
          chk("tap_count", int'(TAP_COUNT), e.tap);
          chk("edge_a", int'(EDGE_A), e.ea);
          chk("edge_b", int'(EDGE_B), e.eb);
          if (e.done != 0) chk("center_tap", int'(CENTER_TAP), e.ct);
          chk("up_pulses", n_up, e.ups);
          chk("down_pulses", n_down, e.downs);
          chk("load_pulses", n_load, e.loads);
          chk("busy_at_end", int'(TRAIN_BUSY), 0);
        end
      end
      prev_fin = fin;
    end
  end

  task automatic pulse_start();
    @(posedge FAB_CLK); #1;
    TRAIN_START = 1'b1;
    @(posedge FAB_CLK); #1;
    TRAIN_START = 1'b0;
  endtask

  task automatic run_scn(input string nm);
    sb.push_back(ref_model());
    pulse_start();
    // A restart request during the sweep must be ignored.
    repeat ($urandom_range(5, 100)) @(posedge FAB_CLK);
    #1;
    if (TRAIN_BUSY) begin
      TRAIN_START = 1'b1;
      @(posedge FAB_CLK); #1;
      TRAIN_START = 1'b0;
    end
    for (int i = 0; i < 20000 && sb.size() != 0; i++) @(posedge FAB_CLK);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout %s: busy=%0d tap=%0d, required a finished run", nm, TRAIN_BUSY,
               TAP_COUNT);
      sb.delete();
    end
    repeat (3) @(posedge FAB_CLK);
  endtask

  task automatic set_edges(input int a, input int wa, input int b, input int wb);
    for (int i = a; i < a + wa; i++) unst[i] = 1'b1;
    for (int i = b; i < b + wb; i++) unst[i] = 1'b1;
  endtask

  initial begin
    clear_cfg();
    #22;
    chk("reset_outputs", int'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                               EYE_MONITOR_CLEAR_FLAGS, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR,
                               ERR_CODE, TAP_COUNT, EDGE_A, EDGE_B, CENTER_TAP} != 0), 0);
    @(posedge FAB_CLK); #1;
    ARST_N = 1'b1;
    repeat (2) @(posedge FAB_CLK);

    clear_cfg();
    set_edges(20, 3, 60, 3);
    run_scn("two_edges");

    clear_cfg();
    run_scn("all_stable");

    clear_cfg();
    set_edges(30, 6, 0, 0);
    run_scn("one_edge");

    clear_cfg();
    late_tap = 10;
    set_edges(50, 1, 0, 0);
    run_scn("eye_flag");

    clear_cfg();
    oor_after = 5;
    run_scn("out_of_range");

    // Reset in the middle of centring, then retrain from scratch.
    clear_cfg();
    set_edges(20, 3, 60, 3);
    pulse_start();
    for (int i = 0; i < 20000 && n_down < 3; i++) @(posedge FAB_CLK);
    #1;
    chk("reached_center", int'(n_down >= 3), 1);
    ARST_N = 1'b0;
    #1;
    chk("reset_mid_center", int'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                                  EYE_MONITOR_CLEAR_FLAGS, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR,
                                  ERR_CODE, TAP_COUNT, EDGE_A, EDGE_B, CENTER_TAP} != 0), 0);
    @(posedge FAB_CLK); #1;
    ARST_N = 1'b1;
    repeat (2) @(posedge FAB_CLK);
    run_scn("after_reset");

    for (int r = 0; r < 4; r++) begin
      int a, wa, b, wb;
      clear_cfg();
      base_val = 8'($urandom);
      alt_val  = base_val ^ 8'($urandom_range(1, 255));
      a  = $urandom_range(1, 40);
      wa = $urandom_range(1, 5);
      b  = $urandom_range(a + wa + 1, 110);
      wb = $urandom_range(1, 3);
      set_edges(a, wa, b, wb);
      run_scn("random_edges");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
